// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - EX-stage bundle between the pipeline and the RV32M sequencer
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            stall_req;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, funct3, op1, op2,
        input  stall_req, busy, done, result
    );

    modport slave (
        input  start, flush, funct3, op1, op2,
        output stall_req, busy, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - RV32M multi-cycle sequencer: one-cycle multiply, restoring divide
module muldiv_seq #(
    parameter int XLEN     = 32,
    parameter int DIV_BITS = 1
) (
    input  logic        clk1,
    input  logic        rst,
    muldiv_seq_if.slave bus
);
    localparam int N  = XLEN / DIV_BITS;
    localparam int CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
    state_t state, state_nxt;

    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] quo, rem, dvs;
    logic [CW-1:0]   cnt;
    logic            sign_q, sign_r, dz_flag, ovf_flag;
    logic            busy_q, done_q;
    logic [XLEN-1:0] result_q;

    logic            accept, in_signed, in_dz, in_ovf;
    logic [XLEN-1:0] mag1, mag2;

    assign accept    = bus.start & ~bus.flush & (state == S_IDLE || state == S_DONE);
    assign in_signed = ~bus.funct3[0];
    assign in_dz     = bus.funct3[2] && (bus.op2 == '0);
    assign in_ovf    = bus.funct3[2] && in_signed && (bus.op1 == MIN_NEG) && (bus.op2 == '1);
    assign mag1      = (in_signed && bus.op1[XLEN-1]) ? -bus.op1 : bus.op1;
    assign mag2      = (in_signed && bus.op2[XLEN-1]) ? -bus.op2 : bus.op2;

    assign bus.stall_req = busy_q | accept;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;

    always_ff @(posedge clk1) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    if (!bus.funct3[2])       state_nxt = S_MUL;
                    else if (in_dz || in_ovf) state_nxt = S_FIX;
                    else                      state_nxt = S_DIV;
                end
            end
            S_MUL:   state_nxt = S_DONE;
            S_DIV:   if (cnt == CW'(1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.flush) state_nxt = S_IDLE;
    end

    // Products are formed at 2*XLEN; sign extension selects the MUL/MULH/MULHSU/MULHU flavour.
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0]   mul_res;
    assign mul_a   = {{XLEN{a_q[XLEN-1] & (op_q != 2'b11)}}, a_q};
    assign mul_b   = {{XLEN{b_q[XLEN-1] & ~op_q[1]}}, b_q};
    assign prod    = mul_a * mul_b;
    assign mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // Restoring steps: the sign bit of the XLEN+1 trial difference decides the quotient bit.
    logic [XLEN-1:0] quo_nxt, rem_nxt;
    logic [XLEN:0]   shifted, diff;
    always_comb begin
        quo_nxt = quo;
        rem_nxt = rem;
        shifted = '0;
        diff    = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            shifted = {rem_nxt, quo_nxt[XLEN-1]};
            diff    = shifted - {1'b0, dvs};
            rem_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            quo_nxt = {quo_nxt[XLEN-2:0], ~diff[XLEN]};
        end
    end

    logic [XLEN-1:0] q_fin, r_fin;
    always_comb begin
        q_fin = (sign_q && !op_q[0]) ? -quo : quo;
        r_fin = (sign_r && !op_q[0]) ? -rem : rem;
        if (dz_flag) begin
            q_fin = '1;
            r_fin = a_q;
        end else if (ovf_flag) begin
            q_fin = MIN_NEG;
            r_fin = '0;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dz_flag  <= 1'b0;
            ovf_flag <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (bus.flush) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op_q     <= bus.funct3[1:0];
                        a_q      <= bus.op1;
                        b_q      <= bus.op2;
                        quo      <= mag1;
                        rem      <= '0;
                        dvs      <= mag2;
                        cnt      <= CW'(N);
                        sign_q   <= bus.op1[XLEN-1] ^ bus.op2[XLEN-1];
                        sign_r   <= bus.op1[XLEN-1];
                        dz_flag  <= in_dz;
                        ovf_flag <= in_ovf;
                        busy_q   <= 1'b1;
                    end
                end
                S_MUL: begin
                    result_q <= mul_res;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                S_DIV: begin
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt - CW'(1);
                end
                S_FIX: begin
                    result_q <= op_q[1] ? r_fin : q_fin;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed-vector bench for muldiv_seq
module tb_muldiv_seq;
    logic clk1 = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    muldiv_seq_if #(.XLEN(32)) bus ();

    muldiv_seq #(.XLEN(32), .DIV_BITS(1)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op1    = a;
        bus.op2    = b;
        #1;
        chk({tag, "_stall_acc"}, 32'(bus.stall_req), 32'd1);
        @(posedge clk1);
        #1;
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.op1    = $urandom;
        bus.op2    = $urandom;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat);
        int lat   = 0;
        int nbusy = 0;
        while (!bus.done && lat < 100) begin
            nbusy += int'(bus.stall_req);
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busycyc"}, 32'(nbusy), 32'(exp_lat));
        chk({tag, "_res"}, bus.result, exp_res);
        chk({tag, "_busy0"}, 32'(bus.busy), 32'd0);
        chk({tag, "_stall0"}, 32'(bus.stall_req), 32'd0);
    endtask

    task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        issue(tag, f3, a, b);
        wait_done(tag, exp_res, exp_lat);
        tick();
        chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        logic        saw_done;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op1    = '0;
        bus.op2    = '0;
        repeat (2) tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_res", bus.result, 32'd0);
        chk("rst_stall", 32'(bus.stall_req), 32'd0);
        rst = 1'b0;
        tick();

        run("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1);
        run("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
        run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1);
        run("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1);

        run("div_m7",  3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run("rem_m7",  3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run("divu",    3'd5, 32'd100, 32'd7, 32'd14, 33);
        run("remu",    3'd7, 32'd100, 32'd7, 32'd2, 33);
        run("div_nd",  3'd4, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);
        run("rem_nd",  3'd6, 32'd100, 32'hFFFFFFF9, 32'd2, 33);
        run("divu_big", 3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);
        run("remu_big", 3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);

        run("div_z",  3'd4, 32'h1234, 32'd0, 32'hFFFFFFFF, 1);
        run("rem_z",  3'd6, 32'h1234, 32'd0, 32'h00001234, 1);
        run("divu_z", 3'd5, 32'h1234, 32'd0, 32'hFFFFFFFF, 1);
        run("remu_z", 3'd7, 32'h1234, 32'd0, 32'h00001234, 1);

        run("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

        // flush during iteration 10 of a divide
        held = bus.result;
        issue("fl", 3'd4, 32'd1000, 32'd3);
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl_busy", 32'(bus.busy), 32'd0);
        chk("fl_stall", 32'(bus.stall_req), 32'd0);
        chk("fl_done", 32'(bus.done), 32'd0);
        chk("fl_res", bus.result, held);
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            saw_done |= bus.done;
        end
        chk("fl_nodone", 32'(saw_done), 32'd0);

        // start with flush in the same cycle is ignored
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        bus.funct3 = 3'd0;
        #1;
        chk("flst_stall", 32'(bus.stall_req), 32'd0);
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flst_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("flst_done", 32'(bus.done), 32'd0);

        run("divu_93", 3'd5, 32'd9, 32'd3, 32'd3, 33);

        // back-to-back: new divide launched in the DONE cycle of a multiply
        issue("b2b_mul", 3'd0, 32'd7, 32'd3);
        wait_done("b2b_mul", 32'd21, 1);
        issue("b2b_div", 3'd4, 32'hFFFFFF9C, 32'd7);
        wait_done("b2b_div", 32'hFFFFFFF2, 33);
        tick();

        // reset in the middle of a divide
        issue("rstm", 3'd5, 32'd500, 32'd5);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("rstm_busy", 32'(bus.busy), 32'd0);
        chk("rstm_done", 32'(bus.done), 32'd0);
        chk("rstm_res", bus.result, 32'd0);
        chk("rstm_stall", 32'(bus.stall_req), 32'd0);
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle sequencer for the RV32M extension in the EX stage. It takes operands and funct3 for an M-type R instruction (funct7 = 0x01) and produces the result. Multiplies complete in one registered cycle. Divides and remainders use an iterative restoring divider. While an operation is in flight it raises stall_req, which the pipeline ORs into its stall, so EX holds the instruction until done.

Parameters:
XLEN, 32, operand/result width
DIV_BITS, 1, quotient bits retired per divide cycle; legal values 1, 2, 4; divide iterations N = XLEN/DIV_BITS

Ports:
clk1  input  1  pipeline clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
start  input  1  launch request, qualified with a valid M-type instruction in EX
flush  input  1  kill the in-flight op (branch redirect)
funct3  input  3  M-op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op1  input  XLEN  rs1 value (dividend / multiplicand)
op2  input  XLEN  rs2 value (divisor / multiplier)
stall_req  output  1  combinational; hold the pipeline
busy  output  1  registered; the op is in flight
done  output  1  registered one-cycle pulse; result valid
result  output  XLEN  registered result, held until next accepted start

Behaviour:
- Reset, on a posedge with rst=1:
  - state=IDLE; busy=0, done=0, result=0.
  - Internal quotient, remainder, divisor, counter and sign flags are cleared.
  - Reset overrides start and flush.
- States: IDLE, MUL, DIV, FIX, DONE.
- Acceptance: start is accepted at an edge when state is IDLE or DONE and flush=0. On acceptance, latch funct3, op1 and op2.
- Dispatch from funct3 at the accept edge (E0):
  - funct3<4: go to MUL.
  - Divide with op2==0: go to FIX; special flag set.
  - Signed DIV/REM with op1==0x80000000 and op2==0xFFFFFFFF: go to FIX; overflow flag set.
  - Otherwise: go to DIV with counter=N and working values loaded.
- Signed divide operands are converted to magnitudes. Record sign_q = op1[XLEN-1]^op2[XLEN-1] and sign_r = op1[XLEN-1].
- MUL state (one cycle), at edge E1: result is the 2*XLEN product slice, then go to DONE.
  - MUL: low half of the signed×signed product.
  - MULH: high half of signed×signed.
  - MULHSU: high half of signed op1 × unsigned op2.
  - MULHU: high half of unsigned×unsigned.
- DIV state:
  - Each edge does DIV_BITS restoring steps: shift remainder:quotient left, trial-subtract the divisor, set the quotient bit if the difference is non-negative.
  - counter decrements each edge; after the edge where counter reaches 0, go to FIX.
  - DIV occupies edges E1..EN.
- FIX state, one edge:
  - DIV/DIVU: result = quotient, negated if sign_q and the op is signed.
  - REM/REMU: result = remainder, negated if sign_r and the op is signed.
  - Divide by zero: quotient=all ones; remainder=op1 unmodified.
  - Overflow: quotient=0x80000000; remainder=0.
  - Then go to DONE.
- DONE: done=1 for exactly one cycle; busy=0. If start=1, it is accepted as from IDLE; otherwise go to IDLE.
- Latency from accept edge E0 to the cycle in which done=1 (counted in edges):
  - Multiplies: 1 edge.
  - Special divides: 1 edge.
  - Normal divides: N+1 edges, i.e. 33 when DIV_BITS=1.
- busy: 1 from the cycle after E0 until the edge that enters DONE.
- stall_req = busy | (start & ~flush & (state==IDLE | state==DONE)). It drops combinationally in the DONE cycle so the pipeline advances exactly once with the valid result.
- Flush: flush=1 at any edge forces IDLE with busy=0 and done=0; result is unchanged; a start in the same cycle is ignored.
- funct3 and operand inputs changing while busy have no effect.
- Arithmetic: all products are computed at 2*XLEN width. Negation is two's complement modulo 2^XLEN.

Test Plan:
- MUL: op1=7, op2=0xFFFFFFFD, start 1 cycle -> done one cycle after accept, result=0xFFFFFFEB. MULHU with op1=op2=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU with op1=0xFFFFFFFF, op2=2 -> 0xFFFFFFFF.
- DIV: op1=0xFFFFFFF9 (-7), op2=2 -> stall_req high 33 cycles, done on cycle 33, result=0xFFFFFFFD. Same operands with REM -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU -> 2.
- Divide by zero, op2=0, op1=0x1234: DIV -> 0xFFFFFFFF; REM -> 0x1234; DIVU -> 0xFFFFFFFF. Each takes 1-edge latency.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. Both take 1-edge latency.
- Flush at iteration 10 of a DIV -> next cycle busy=0, stall_req=0, no done pulse, result unchanged. A fresh DIVU 9/3 then returns 3 after 33 edges.
- Back-to-back: start held high in the DONE cycle of a MUL with a new DIV -> accepted, no idle gap, correct DIV result. Reset asserted mid-DIV -> all outputs 0 next cycle.
